// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int GUARD_CYC = 1;
    localparam int MAX_REQ   = 8;

    // Modular add for indices that are already below n.
    function automatic int wrapAdd(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_sel
);

    // Scan farthest-first so the nearest hit from the pointer is written last.
    always_comb begin
        o_any = 1'b0;
        o_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[wrapAdd(int'(i_ptr), k, NUM_REQ)]) begin
                o_any = 1'b1;
                o_sel = ID_W'(wrapAdd(int'(i_ptr), k, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte sources.
// Optional packet locking is enabled with the UART_TX_ARB_PKT_LOCK_EN macro.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    state_t             r_state;
    state_t             w_nextState;
    logic               r_txEn;
    logic [7:0]         r_txData;
    logic [ID_W-1:0]    r_grantId;
    logic [ID_W-1:0]    r_rrPtr;
    logic [3:0]         r_guardCnt;

    logic [NUM_REQ-1:0] w_pickReq;
    logic [ID_W-1:0]    w_pickPtr;
    logic [ID_W-1:0]    w_rrNext;
    logic               w_any;
    logic [ID_W-1:0]    w_sel;
    logic               w_accept;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .i_req (w_pickReq),
        .i_ptr (w_pickPtr),
        .o_any (w_any),
        .o_sel (w_sel)
    );

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic r_lock;
    logic w_selLast;

    assign w_selLast = req_last[w_sel];
    assign w_pickReq = r_lock ? (req_valid & (NUM_REQ'(1) << r_grantId)) : req_valid;
    assign w_pickPtr = r_lock ? r_grantId : r_rrPtr;
    assign w_rrNext  = w_selLast ? ID_W'(wrapAdd(int'(w_sel), 1, NUM_REQ)) : r_rrPtr;

    // Stay locked to the current requester until it delivers its last byte.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_lock <= 1'b0;
        else if (w_accept)
            r_lock <= !w_selLast;
    end
`else
    logic w_unusedLast;

    assign w_unusedLast = ^req_last;
    assign w_pickReq    = req_valid;
    assign w_pickPtr    = r_rrPtr;
    assign w_rrNext     = ID_W'(wrapAdd(int'(w_sel), 1, NUM_REQ));
`endif

    assign w_accept = (r_state == IDLE) && uart_tx_ready && w_any;

    always_comb begin
        req_ready = '0;
        if (w_accept)
            req_ready[w_sel] = 1'b1;
    end

    // GUARD masks the stale tx_ready=1 before the serializer reacts to tx_en.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_nextState = ISSUE;
            ISSUE: w_nextState = GUARD;
            GUARD: if (r_guardCnt == 4'(GUARD_CYC - 1)) w_nextState = WAIT;
            WAIT:  if (uart_tx_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_txEn     <= 1'b0;
            r_txData   <= '0;
            r_grantId  <= '0;
            r_rrPtr    <= '0;
            r_guardCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_txEn     <= w_accept;
            r_guardCnt <= (r_state == GUARD) ? r_guardCnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_txData  <= req_data[{w_sel, 3'b000} +: 8];
                r_grantId <= w_sel;
                r_rrPtr   <= w_rrNext;
            end
        end
    end

    assign uart_tx_en   = r_txEn;
    assign uart_tx_data = r_txData;
    assign grant_id     = r_grantId;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a behavioural 10-clk/bit uart_tx model.
module tb_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx_en;
    logic [7:0]           uart_tx_data;
    logic                 txReady = 1'b1;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    int checks    = 0;
    int failures  = 0;
    int rdyCycles = 0;
    int txEnCount = 0;

    logic [8:0]        reqQ[NUM_REQ][$];
    logic [ID_W+7:0]   expQ[$];
    logic [7:0]        rxQ[$];

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (txReady),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: reacts to tx_en one cycle late, then 10 bits of 10 clocks.
    logic       txLine   = 1'b1;
    logic       pend     = 1'b0;
    logic [7:0] pendData = 8'h00;
    logic [9:0] shReg    = 10'h3ff;
    int         bitCnt   = 0;
    int         clkCnt   = 0;

    always @(posedge clk) begin
        if (txReady) begin
            if (pend) begin
                txReady <= 1'b0;
                shReg   <= {1'b1, pendData, 1'b0};
                txLine  <= 1'b0;
                bitCnt  <= 0;
                clkCnt  <= 0;
                pend    <= 1'b0;
            end else if (uart_tx_en) begin
                pend     <= 1'b1;
                pendData <= uart_tx_data;
            end
        end else if (clkCnt == 9) begin
            clkCnt <= 0;
            if (bitCnt == 9) begin
                txReady <= 1'b1;
                txLine  <= 1'b1;
            end else begin
                bitCnt <= bitCnt + 1;
                txLine <= shReg[bitCnt + 1];
            end
        end else begin
            clkCnt <= clkCnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
        reqQ[id].push_back({last, data});
    endtask

    task automatic pushExpected(input int id, input logic [7:0] data);
        expQ.push_back({ID_W'(id), data});
        rxQ.push_back(data);
    endtask

    // Requester driver: holds each byte until its handshake is seen.
    initial begin : driver
        logic [NUM_REQ-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && reqQ[i].size() > 0)
                    void'(reqQ[i].pop_front());
                if (reqQ[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*8 +: 8]   = reqQ[i][0][7:0];
                    req_last[i]          = reqQ[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every tx_en pulse must match the head of the scoreboard.
    initial begin : monitor
        logic            prevEn;
        logic [ID_W+7:0] exp;
        prevEn = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_en) begin
                txEnCount++;
                checkOutput("txEnSingleCycle", 32'(prevEn), 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedTxEn actual id=%0d data=0x%0h expected none", grant_id, uart_tx_data);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("grantAndData", 32'({grant_id, uart_tx_data}), 32'(exp));
                end
            end
            if (req_ready != '0) begin
                rdyCycles++;
                checkOutput("readyOneHotValid",
                            32'(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
            end
            prevEn = uart_tx_en;
        end
    end

    // Line receiver: decodes each frame mid-bit and checks it against the byte order.
    initial begin : receiver
        logic [7:0] rxByte;
        logic       startBit;
        logic       stopBit;
        logic [7:0] expB;
        forever begin
            @(negedge txLine);
            repeat (5) @(negedge clk);
            startBit = txLine;
            for (int b = 0; b < 8; b++) begin
                repeat (10) @(negedge clk);
                rxByte[b] = txLine;
            end
            repeat (10) @(negedge clk);
            stopBit = txLine;
            if (rxQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rxUnexpected actual=0x%0h expected none", rxByte);
            end else begin
                expB = rxQ.pop_front();
                checkOutput("rxFrame", 32'({startBit, rxByte, stopBit}), 32'({1'b0, expB, 1'b1}));
            end
        end
    end

    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(posedge clk);
            #1;
            done = (reqQ[0].size() == 0) && (reqQ[1].size() == 0) && (reqQ[2].size() == 0) &&
                   (reqQ[3].size() == 0) && !busy && txReady && !pend &&
                   (expQ.size() == 0) && (rxQ.size() == 0);
        end
        checkOutput({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic waitTxEn(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            seen = uart_tx_en;
        end
        checkOutput({name, "_txEnSeen"}, 32'(seen), 32'd1);
    endtask

    task automatic resetIdle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        bit readyLeak;
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetTxEn",   32'(uart_tx_en),   32'd0);
        checkOutput("resetTxData", 32'(uart_tx_data), 32'd0);
        checkOutput("resetGrant",  32'(grant_id),     32'd0);
        checkOutput("resetBusy",   32'(busy),         32'd0);
        checkOutput("resetReady",  32'(req_ready),    32'd0);
        rst_n = 1'b1;

        $display("[TB] single request");
        rdyCycles = 0;
        applyStimulus(0, 8'hA5, 1'b1);
        pushExpected(0, 8'hA5);
        waitTxEn("single");
        repeat (5) @(negedge clk);
        checkOutput("singleBusy", 32'(busy), 32'd1);
        checkOutput("singleDataHeld", 32'(uart_tx_data), 32'hA5);
        waitIdle("single");
        checkOutput("singleReadyCycles", 32'(rdyCycles), 32'd1);

        $display("[TB] four requesters round robin");
        resetIdle();
        txEnCount = 0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 8'h10 + 8'(i), 1'b1);
        applyStimulus(0, 8'h14, 1'b1);
        pushExpected(0, 8'h10);
        pushExpected(1, 8'h11);
        pushExpected(2, 8'h12);
        pushExpected(3, 8'h13);
        pushExpected(0, 8'h14);
        waitIdle("roundRobin");
        checkOutput("roundRobinTxEnCount", 32'(txEnCount), 32'd5);

        $display("[TB] twenty back-to-back frames");
        rdyCycles = 0;
        txEnCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'h20 + 8'(i), 1'b1);
            pushExpected(1, 8'h20 + 8'(i));
        end
        waitIdle("guard");
        checkOutput("guardTxEnCount", 32'(txEnCount), 32'd20);
        checkOutput("guardReadyCycles", 32'(rdyCycles), 32'd20);

        $display("[TB] reset mid-frame");
        applyStimulus(3, 8'h5C, 1'b1);
        pushExpected(3, 8'h5C);
        waitTxEn("midReset");
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midResetTxEn",   32'(uart_tx_en),   32'd0);
        checkOutput("midResetTxData", 32'(uart_tx_data), 32'd0);
        checkOutput("midResetGrant",  32'(grant_id),     32'd0);
        checkOutput("midResetBusy",   32'(busy),         32'd0);
        applyStimulus(2, 8'h3E, 1'b1);
        pushExpected(2, 8'h3E);
        rst_n = 1'b1;
        readyLeak = 1'b0;
        n = 0;
        while (!txReady && n < 300) begin
            @(negedge clk);
            if (!txReady && req_ready != '0) readyLeak = 1'b1;
            n++;
        end
        checkOutput("midResetNoEarlyAccept", 32'(readyLeak), 32'd0);
        waitIdle("midReset");

        $display("[TB] packet lock ordering");
        resetIdle();
        applyStimulus(0, 8'h40, 1'b0);
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b1);
        applyStimulus(1, 8'h50, 1'b1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
        pushExpected(0, 8'h40);
        pushExpected(0, 8'h41);
        pushExpected(0, 8'h42);
        pushExpected(1, 8'h50);
`else
        pushExpected(0, 8'h40);
        pushExpected(1, 8'h50);
        pushExpected(0, 8'h41);
        pushExpected(0, 8'h42);
`endif
        waitIdle("lock");

        $display("[TB] dropped valid");
        resetIdle();
        applyStimulus(1, 8'h60, 1'b1);
        pushExpected(1, 8'h60);
        waitTxEn("drop");
        n = 0;
        while (txReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        applyStimulus(2, 8'h70, 1'b1);
        repeat (20) @(negedge clk);
        reqQ[2].delete();
        applyStimulus(3, 8'h71, 1'b1);
        pushExpected(3, 8'h71);
        waitIdle("drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
